stopwatch_ctrl: RTL and testbench

Button-driven run controller for the stopwatch counter. It synchronizes and debounces three raw board buttons (start/stop, lap, clear), turns each into a single-cycle press event, and runs a four-state FSM. The FSM outputs drive the counter's count enable, its synchronous clear, and the lap-freeze path of the display. It sits between the board button pins and the stopwatch datapath, in the same clock domain.

---
 rtl/stopwatch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Run controller for the stopwatch counter. The three raw board buttons each
// pass through a two-flop synchronizer and a debouncer. The debouncer turns
// every accepted press into a single-cycle event. A four-state FSM
// (IDLE/RUN/LAP/STOP) consumes these events and drives the counter and
// display control lines. All outputs are registered.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a level (>= 2)
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high; clears all state
//   btn_start_stop  raw start/stop button, active-high
//   btn_lap         raw lap button, active-high
//   btn_clear       raw clear button, active-high
//   count_en        counter may advance (RUN, LAP)
//   count_clr       one-cycle synchronous clear pulse to the counter digits
//   lap_load        one-cycle pulse; the display latches the live digits
//   display_freeze  display shows the latched lap value (LAP only)
//   state           current FSM state for status LEDs
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_load,
  output logic       display_freeze,
  output logic [1:0] state
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_meta;
  logic [2:0]    r_sync;
  logic [2:0]    r_stable;
  logic [2:0]    r_press;
  logic [CW-1:0] r_cnt [3];

  state_t r_state;
  state_t w_next_state;
  logic   w_clr_next;
  logic   w_lap_next;
  logic   r_count_en;
  logic   r_count_clr;
  logic   r_lap_load;
  logic   r_display_freeze;

  assign w_raw = {btn_clear, btn_lap, btn_start_stop};

  // Input path: synchronizer, debounce counter and press-event register for
  // all three buttons. The press event is registered on the same edge that
  // `stable` rises, so it needs no separate edge detector.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_stable <= '0;
      r_press  <= '0;
      // NOTE: the debounce counters are a small array but must still be
      // reset, otherwise a press during reset could be accepted early.
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync[i];
          r_cnt[i]    <= '0;
          // Only an accepted 0->1 transition is an event; releases are silent.
          r_press[i]  <= r_sync[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Next-state and next-output logic. Priority start_stop > clear > lap: only
  // the highest-priority event present is evaluated, even when that event is
  // ignored in the current state.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_clr_next   = 1'b0;
    w_lap_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_press[BTN_SS])       w_next_state = ST_RUN;
        else if (r_press[BTN_CLR]) w_clr_next   = 1'b1;
      end
      ST_RUN: begin
        if (r_press[BTN_SS]) begin
          w_next_state = ST_STOP;
        end else if (!r_press[BTN_CLR] && r_press[BTN_LAP]) begin
          w_next_state = ST_LAP;
          w_lap_next   = 1'b1;
        end
      end
      ST_LAP: begin
        if (r_press[BTN_SS])       w_next_state = ST_STOP;
        else if (r_press[BTN_CLR]) w_next_state = ST_RUN;
        else if (r_press[BTN_LAP]) w_lap_next   = 1'b1;
      end
      ST_STOP: begin
        if (r_press[BTN_SS]) begin
          w_next_state = ST_RUN;
        end else if (r_press[BTN_CLR]) begin
          w_next_state = ST_IDLE;
          w_clr_next   = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and output registers. The Moore outputs are decoded from the next
  // state so they change on the same edge as `state`.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_count_en       <= 1'b0;
      r_count_clr      <= 1'b0;
      r_lap_load       <= 1'b0;
      r_display_freeze <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_count_en       <= (w_next_state == ST_RUN) || (w_next_state == ST_LAP);
      r_count_clr      <= w_clr_next;
      r_lap_load       <= w_lap_next;
      r_display_freeze <= (w_next_state == ST_LAP);
    end
  end

  assign state          = r_state;
  assign count_en       = r_count_en;
  assign count_clr      = r_count_clr;
  assign lap_load       = r_lap_load;
  assign display_freeze = r_display_freeze;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES = 4 (press to FSM
// output latency of 7 edges). Expected output snapshots are queued when a
// button is driven and popped as the DUT reaches each checkpoint. Snapshot
// bit layout: {state[1:0], count_en, display_freeze, count_clr, lap_load}.
// Pulse counters sampled on the falling edge confirm pulse counts and widths.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int D = 4;

  localparam logic [5:0] S_IDLE = 6'b00_0000;
  localparam logic [5:0] S_RUN  = 6'b01_1000;
  localparam logic [5:0] S_LAP  = 6'b10_1100;
  localparam logic [5:0] S_STOP = 6'b11_0000;
  localparam logic [5:0] P_CLR_IDLE = 6'b00_0010;
  localparam logic [5:0] P_LAP_LAP  = 6'b10_1101;

  localparam logic [2:0] M_SS  = 3'b001;
  localparam logic [2:0] M_LAP = 3'b010;
  localparam logic [2:0] M_CLR = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       count_en;
  logic       count_clr;
  logic       lap_load;
  logic       display_freeze;
  logic [1:0] state;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   clr_seen = 0;
  int   lap_seen = 0;
  int   exp_clr  = 0;
  int   exp_lap  = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .count_en       (count_en),
    .count_clr      (count_clr),
    .lap_load       (lap_load),
    .display_freeze (display_freeze),
    .state          (state)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (count_clr === 1'b1) clr_seen++;
    if (lap_load === 1'b1)  lap_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] obs();
    return {state, count_en, display_freeze, count_clr, lap_load};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mask);
    {btn_clear, btn_lap, btn_start_stop} = mask;
  endtask

  task automatic sb_push(input string tag, input logic [5:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, 32'(obs()), 32'(e.exp));
    end
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_clr_count"}, 32'(clr_seen), 32'(exp_clr));
    check({tag, "_lap_count"}, 32'(lap_seen), 32'(exp_lap));
  endtask

  // Press the buttons in `mask`, hold for `hold` cycles, release and settle.
  // Checks the state one edge before the expected response, on the response
  // edge (including any pulse), one edge later (pulse gone), and after release.
  task automatic press(input string tag, input logic [2:0] mask, input int hold,
                       input logic [5:0] exp_before, input logic [5:0] exp_pulse,
                       input logic [5:0] exp_after);
    drive(mask);
    sb_push({tag, "_pre"},    exp_before);
    sb_push({tag, "_edge"},   exp_pulse);
    sb_push({tag, "_next"},   exp_after);
    sb_push({tag, "_settle"}, exp_after);
    exp_clr += int'(exp_pulse[1]);
    exp_lap += int'(exp_pulse[0]);
    step(D + 2);
    sb_check();
    step(1);
    sb_check();
    step(1);
    sb_check();
    if (hold > D + 4) step(hold - (D + 4));
    drive(3'b000);
    step(12);
    sb_check();
    check_pulses(tag);
  endtask

  initial begin
    // 1a: plain reset for 5 cycles.
    step(5);
    sb_push("reset_hold", S_IDLE);
    sb_check();
    reset = 1'b0;
    sb_push("reset_release", S_IDLE);
    step(2);
    sb_check();

    // 1b: start_stop held through reset release is a new press after full latency.
    reset = 1'b1;
    drive(M_SS);
    step(3);
    reset = 1'b0;
    sb_push("held_reset_pre",  S_IDLE);
    sb_push("held_reset_edge", S_RUN);
    step(D + 2);
    sb_check();
    step(1);
    sb_check();
    drive(3'b000);
    step(12);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    sb_push("reset_back_idle", S_IDLE);
    step(1);
    sb_check();
    check_pulses("reset");

    // 3: bounce shorter than the debounce window gives no event.
    drive(M_SS); step(2);
    drive(3'b000); step(1);
    drive(M_SS); step(2);
    drive(3'b000);
    sb_push("bounce", S_IDLE);
    step(12);
    sb_check();
    check_pulses("bounce");

    // 2: start_stop held for 20 cycles -> RUN after exactly 7 edges, once.
    press("start_hold", M_SS, 20, S_IDLE, S_RUN, S_RUN);

    // 4: lap, lap again, clear back to RUN without count_clr.
    press("lap1",      M_LAP, 10, S_RUN, P_LAP_LAP, S_LAP);
    press("lap2",      M_LAP, 10, S_LAP, P_LAP_LAP, S_LAP);
    press("lap_clear", M_CLR, 10, S_LAP, S_RUN,     S_RUN);

    // 5: stop, clear to IDLE, clear in IDLE.
    press("stop",       M_SS,  10, S_RUN,  S_STOP,     S_STOP);
    press("stop_clear", M_CLR, 10, S_STOP, P_CLR_IDLE, S_IDLE);
    press("idle_clear", M_CLR, 10, S_IDLE, P_CLR_IDLE, S_IDLE);

    // 6: simultaneous events.
    press("to_run",  M_SS,         10, S_IDLE, S_RUN,  S_RUN);
    press("to_stop", M_SS,         10, S_RUN,  S_STOP, S_STOP);
    press("ss_clr",  M_SS | M_CLR, 10, S_STOP, S_RUN,  S_RUN);
    press("clr_lap", M_CLR | M_LAP, 10, S_RUN, S_RUN,  S_RUN);
    press("to_lap",  M_LAP,        10, S_RUN, P_LAP_LAP, S_LAP);

    // Asynchronous reset while in LAP: outputs drop before any clock edge.
    reset = 1'b1;
    sb_push("async_reset", S_IDLE);
    #1;
    sb_check();
    step(2);
    reset = 1'b0;
    sb_push("final_idle", S_IDLE);
    step(3);
    sb_check();
    check_pulses("final");
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
